// File: rtl/axi4_stream_packet_merger.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_stream_packet_merger
//  Description : Two-input, one-output AXI4-Stream merger. Round-robin
//                arbitration at packet granularity (TLAST-delimited), one
//                whole packet forwarded at a time through a registered output
//                stage, each output beat tagged with its source port in TID.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_stream_packet_merger #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  AXIS_ACLK,
    input  logic                  AXIS_ARESET,
    // Port 1 slave
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA1,
    input  logic                  S_AXIS_TVALID1,
    input  logic                  S_AXIS_TLAST1,
    output logic                  S_AXIS_TREADY1,
    // Port 2 slave
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA2,
    input  logic                  S_AXIS_TVALID2,
    input  logic                  S_AXIS_TLAST2,
    output logic                  S_AXIS_TREADY2,
    // Merged master
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TID,
    input  logic                  M_AXIS_TREADY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK1 = 2'd1,
        ST_LOCK2 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    // Port that won the most recent grant: 0 = port 1, 1 = port 2
    logic                  last_grant_q, last_grant_d;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  out_last_q,  out_last_d;
    logic                  out_id_q,    out_id_d;

    logic                  out_free;
    logic                  ready1;
    logic                  ready2;
    logic                  accept1;
    logic                  accept2;

    // The output register can take a beat when empty or draining this cycle.
    // Slave readiness never looks at slave TVALID.
    assign out_free = !out_valid_q || M_AXIS_TREADY;
    assign ready1   = (state_q == ST_LOCK1) && out_free;
    assign ready2   = (state_q == ST_LOCK2) && out_free;
    assign accept1  = S_AXIS_TVALID1 && ready1;
    assign accept2  = S_AXIS_TVALID2 && ready2;

    assign S_AXIS_TREADY1 = ready1;
    assign S_AXIS_TREADY2 = ready2;

    assign M_AXIS_TDATA  = out_data_q;
    assign M_AXIS_TVALID = out_valid_q;
    assign M_AXIS_TLAST  = out_last_q;
    assign M_AXIS_TID    = out_id_q;

    // State and arbitration history registers
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state: grant in IDLE (round-robin on contention), hold lock until TLAST accepted
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (S_AXIS_TVALID1 && S_AXIS_TVALID2) begin
                    if (last_grant_q) begin
                        state_d      = ST_LOCK1;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = ST_LOCK2;
                        last_grant_d = 1'b1;
                    end
                end else if (S_AXIS_TVALID1) begin
                    state_d      = ST_LOCK1;
                    last_grant_d = 1'b0;
                end else if (S_AXIS_TVALID2) begin
                    state_d      = ST_LOCK2;
                    last_grant_d = 1'b1;
                end
            end
            ST_LOCK1: begin
                if (accept1 && S_AXIS_TLAST1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK2: begin
                if (accept2 && S_AXIS_TLAST2) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage next value: load on accept, clear on drain, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;
        if (accept1) begin
            out_valid_d = 1'b1;
            out_data_d  = S_AXIS_TDATA1;
            out_last_d  = S_AXIS_TLAST1;
            out_id_d    = 1'b0;
        end else if (accept2) begin
            out_valid_d = 1'b1;
            out_data_d  = S_AXIS_TDATA2;
            out_last_d  = S_AXIS_TLAST2;
            out_id_d    = 1'b1;
        end else if (M_AXIS_TREADY) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register; reset abandons any beat in flight
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_id_q    <= out_id_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_stream_packet_merger.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_stream_packet_merger
//  Description : Directed self-checking bench for axi4_stream_packet_merger.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_stream_packet_merger;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tdata1 = '0;
    logic [31:0] tdata2 = '0;
    logic        tvalid1 = 1'b0;
    logic        tvalid2 = 1'b0;
    logic        tlast1 = 1'b0;
    logic        tlast2 = 1'b0;
    logic        tready1;
    logic        tready2;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tid;
    logic        mready = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Source queues hold {last, data}; output log holds {tid, last, data}
    logic [32:0] q1[$];
    logic [32:0] q2[$];
    bit          en1 = 1'b1;
    bit          en2 = 1'b1;
    logic [33:0] out_q[$];
    int          out_cyc[$];
    int          acc1_cyc[$];
    int          acc2_cyc[$];

    // Values sampled just before the most recent clock edge
    bit          f1, f2, tr1_s, tr2_s, mr_s, pv;
    logic [31:0] pd;
    logic        pl, pt;

    always #5 clk = ~clk;

    axi4_stream_packet_merger #(.DATA_WIDTH(32)) dut (
        .AXIS_ACLK      (clk),
        .AXIS_ARESET    (rst),
        .S_AXIS_TDATA1  (tdata1),
        .S_AXIS_TVALID1 (tvalid1),
        .S_AXIS_TLAST1  (tlast1),
        .S_AXIS_TREADY1 (tready1),
        .S_AXIS_TDATA2  (tdata2),
        .S_AXIS_TVALID2 (tvalid2),
        .S_AXIS_TLAST2  (tlast2),
        .S_AXIS_TREADY2 (tready2),
        .M_AXIS_TDATA   (m_tdata),
        .M_AXIS_TVALID  (m_tvalid),
        .M_AXIS_TLAST   (m_tlast),
        .M_AXIS_TID     (m_tid),
        .M_AXIS_TREADY  (mready)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every beat the downstream side accepts
    always @(posedge clk) begin
        if (!rst && m_tvalid && mready) begin
            out_q.push_back({m_tid, m_tlast, m_tdata});
            out_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_logs();
        out_q.delete();
        out_cyc.delete();
        acc1_cyc.delete();
        acc2_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tvalid1 = 1'b0; tvalid2 = 1'b0; tlast1 = 1'b0; tlast2 = 1'b0;
        mready = 1'b0;
        q1.delete(); q2.delete();
        en1 = 1'b1; en2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
    endtask

    // One clock: present queue heads, sample handshakes, advance past the edge
    task automatic cycle();
        tvalid1 = en1 && (q1.size() > 0);
        tdata1  = tvalid1 ? q1[0][31:0] : 32'h0;
        tlast1  = tvalid1 ? q1[0][32]   : 1'b0;
        tvalid2 = en2 && (q2.size() > 0);
        tdata2  = tvalid2 ? q2[0][31:0] : 32'h0;
        tlast2  = tvalid2 ? q2[0][32]   : 1'b0;
        #1;
        f1 = tvalid1 && tready1;
        f2 = tvalid2 && tready2;
        tr1_s = tready1; tr2_s = tready2; mr_s = mready;
        pv = m_tvalid; pd = m_tdata; pl = m_tlast; pt = m_tid;
        if (f1) acc1_cyc.push_back(cyc);
        if (f2) acc2_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        if (f1) void'(q1.pop_front());
        if (f2) void'(q2.pop_front());
    endtask

    task automatic test_reset();
        tvalid1 = 1'b1; tvalid2 = 1'b1;
        @(posedge clk);
        #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
        total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
        total++; if (m_tid !== 1'b0) begin bad++; $display("FAIL reset_tid: got %b want 0", m_tid); end
        total++; if (m_tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
        total++; if (tready1 !== 1'b0) begin bad++; $display("FAIL reset_tready1: got %b want 0", tready1); end
        total++; if (tready2 !== 1'b0) begin bad++; $display("FAIL reset_tready2: got %b want 0", tready2); end
        tvalid1 = 1'b0; tvalid2 = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        clear_logs();
    endtask

    task automatic test_single_source();
        logic [33:0] exp, got;
        int lat, span;
        do_reset();
        mready = 1'b1;
        for (int i = 0; i < 4; i++) q1.push_back({1'(i == 3), 32'(32'h10 + i)});
        for (int k = 0; k < 30 && out_q.size() < 4; k++) cycle();
        total++; if (out_q.size() != 4) begin bad++; $display("FAIL single_count: got %0d want 4", out_q.size()); end
        for (int i = 0; i < 4; i++) begin
            exp = {1'b0, 1'(i == 3), 32'(32'h10 + i)};
            got = (i < out_q.size()) ? out_q[i] : 34'bx;
            total++; if (got !== exp) begin bad++; $display("FAIL single_beat%0d: got %h want %h", i, got, exp); end
        end
        lat  = (out_q.size() == 4 && acc1_cyc.size() == 4) ? out_cyc[0] - acc1_cyc[0] : -1;
        span = (out_q.size() == 4) ? out_cyc[3] - out_cyc[0] : -1;
        total++; if (lat != 1) begin bad++; $display("FAIL single_latency: got %0d want 1", lat); end
        total++; if (span != 3) begin bad++; $display("FAIL single_throughput: got %0d want 3", span); end
    endtask

    task automatic test_contention();
        logic [33:0] exp, got;
        int gap, want;
        logic [31:0] d;
        do_reset();
        mready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < 3; b++) begin
                q1.push_back({1'(b == 2), 32'(b + 1)});
                q2.push_back({1'(b == 2), 32'(-(b + 1))});
            end
        end
        for (int k = 0; k < 80 && out_q.size() < 12; k++) cycle();
        total++; if (out_q.size() != 12) begin bad++; $display("FAIL contention_count: got %0d want 12", out_q.size()); end
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 3; b++) begin
                d   = (p % 2 == 1) ? 32'(-(b + 1)) : 32'(b + 1);
                exp = {1'(p % 2), 1'(b == 2), d};
                got = (p * 3 + b < out_q.size()) ? out_q[p * 3 + b] : 34'bx;
                total++; if (got !== exp) begin bad++; $display("FAIL contention_beat%0d: got %h want %h", p * 3 + b, got, exp); end
            end
        end
        for (int k = 1; k < 12; k++) begin
            gap  = (out_q.size() == 12) ? out_cyc[k] - out_cyc[k - 1] : -1;
            want = (k % 3 == 0) ? 2 : 1;
            total++; if (gap != want) begin bad++; $display("FAIL contention_gap%0d: got %0d want %0d", k, gap, want); end
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] exp, got;
        int stalls;
        do_reset();
        stalls = 0;
        for (int i = 0; i < 5; i++) q2.push_back({1'(i == 4), 32'(32'h20 + i)});
        for (int k = 0; k < 80 && out_q.size() < 5; k++) begin
            mready = (k % 4 == 0) || (k % 4 == 3);
            cycle();
            if (pv && !mr_s) begin
                stalls++;
                total++;
                if ({m_tvalid, m_tdata, m_tlast, m_tid} !== {1'b1, pd, pl, pt}) begin
                    bad++;
                    $display("FAIL bp_stable: got %b/%h/%b/%b want 1/%h/%b/%b",
                             m_tvalid, m_tdata, m_tlast, m_tid, pd, pl, pt);
                end
                total++; if (tr2_s !== 1'b0) begin bad++; $display("FAIL bp_tready2: got %b want 0", tr2_s); end
            end
        end
        total++; if (stalls == 0) begin bad++; $display("FAIL bp_stalls: got 0 want >0"); end
        total++; if (out_q.size() != 5) begin bad++; $display("FAIL bp_count: got %0d want 5", out_q.size()); end
        for (int i = 0; i < 5; i++) begin
            exp = {1'b1, 1'(i == 4), 32'(32'h20 + i)};
            got = (i < out_q.size()) ? out_q[i] : 34'bx;
            total++; if (got !== exp) begin bad++; $display("FAIL bp_beat%0d: got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_single_beat();
        logic [33:0] exp, got;
        int gap;
        do_reset();
        mready = 1'b1;
        for (int i = 0; i < 3; i++) q1.push_back({1'b1, 32'(7 + i)});
        for (int k = 0; k < 30 && out_q.size() < 3; k++) cycle();
        for (int i = 0; i < 3; i++) begin
            exp = {1'b0, 1'b1, 32'(7 + i)};
            got = (i < out_q.size()) ? out_q[i] : 34'bx;
            total++; if (got !== exp) begin bad++; $display("FAIL sbeat_beat%0d: got %h want %h", i, got, exp); end
        end
        for (int i = 1; i < 3; i++) begin
            gap = (out_q.size() == 3) ? out_cyc[i] - out_cyc[i - 1] : -1;
            total++; if (gap != 2) begin bad++; $display("FAIL sbeat_gap%0d: got %0d want 2", i, gap); end
        end
    endtask

    task automatic test_gapped();
        logic [33:0] exp[3];
        logic [33:0] got;
        int order;
        do_reset();
        mready = 1'b1;
        q1.push_back({1'b0, 32'hA});
        q1.push_back({1'b1, 32'hB});
        q2.push_back({1'b1, 32'h55});
        for (int k = 0; k < 20 && q1.size() > 1; k++) cycle();
        en1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++; if (tr2_s !== 1'b0) begin bad++; $display("FAIL gap_tready2_gap%0d: got %b want 0", k, tr2_s); end
        end
        en1 = 1'b1;
        for (int k = 0; k < 20 && q1.size() > 0; k++) begin
            cycle();
            total++; if (tr2_s !== 1'b0) begin bad++; $display("FAIL gap_tready2_tail: got %b want 0", tr2_s); end
        end
        for (int k = 0; k < 20 && out_q.size() < 3; k++) cycle();
        exp[0] = {1'b0, 1'b0, 32'hA};
        exp[1] = {1'b0, 1'b1, 32'hB};
        exp[2] = {1'b1, 1'b1, 32'h55};
        for (int i = 0; i < 3; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 34'bx;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL gap_beat%0d: got %h want %h", i, got, exp[i]); end
        end
        order = (acc1_cyc.size() == 2 && acc2_cyc.size() == 1) ? acc2_cyc[0] - acc1_cyc[1] : -1;
        total++; if (order < 1) begin bad++; $display("FAIL gap_grant_order: got %0d want >=1", order); end
    endtask

    task automatic test_reset_mid();
        logic [33:0] got;
        do_reset();
        mready = 1'b1;
        for (int i = 0; i < 4; i++) q1.push_back({1'(i == 3), 32'(32'h30 + i)});
        for (int k = 0; k < 20 && q1.size() > 2; k++) cycle();
        mready = 1'b0;
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL rmid_pre_tvalid: got %b want 1", m_tvalid); end
        #2 rst = 1'b1;
        #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rmid_tvalid: got %b want 0", m_tvalid); end
        total++; if (m_tdata !== 32'h0) begin bad++; $display("FAIL rmid_tdata: got %h want 0", m_tdata); end
        total++; if (tready1 !== 1'b0) begin bad++; $display("FAIL rmid_tready1: got %b want 0", tready1); end
        total++; if (tready2 !== 1'b0) begin bad++; $display("FAIL rmid_tready2: got %b want 0", tready2); end
        q1.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        mready = 1'b1;
        q1.push_back({1'b1, 32'h77});
        q2.push_back({1'b1, 32'h88});
        for (int k = 0; k < 20 && out_q.size() < 2; k++) cycle();
        got = (out_q.size() > 0) ? out_q[0] : 34'bx;
        total++; if (got !== {1'b0, 1'b1, 32'h77}) begin bad++; $display("FAIL rmid_first: got %h want %h", got, {1'b0, 1'b1, 32'h77}); end
        got = (out_q.size() > 1) ? out_q[1] : 34'bx;
        total++; if (got !== {1'b1, 1'b1, 32'h88}) begin bad++; $display("FAIL rmid_second: got %h want %h", got, {1'b1, 1'b1, 32'h88}); end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_contention();
        test_backpressure();
        test_single_beat();
        test_gapped();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_stream_packet_merger.md
# axi4_stream_packet_merger

Two-input, one-output AXI4-Stream merger: the converging counterpart of our one-to-two stream fan-out. Arbitrates round-robin between two upstream streams at packet granularity (TLAST-delimited), forwards one whole packet at a time through a registered output stage, and tags each output beat with its source port. Sits where two audio or processed-sample streams must share one downstream consumer.

## Interface
- DATA_WIDTH, 32, width of TDATA on all ports (signed samples, passed through untouched)
- AXIS_ACLK  input  1  stream clock; all logic on rising edge
- AXIS_ARESET  input  1  asynchronous, active-high reset
- S_AXIS_TDATA1  input  DATA_WIDTH  port 1 data (signed)
- S_AXIS_TVALID1  input  1  port 1 valid
- S_AXIS_TLAST1  input  1  port 1 end of packet
- S_AXIS_TREADY1  output  1  port 1 ready
- S_AXIS_TDATA2 / S_AXIS_TVALID2 / S_AXIS_TLAST2 / S_AXIS_TREADY2  as port 1, for port 2
- M_AXIS_TDATA  output  DATA_WIDTH  merged data (signed)
- M_AXIS_TVALID  output  1  merged valid
- M_AXIS_TLAST  output  1  merged end of packet
- M_AXIS_TID  output  1  source of current beat: 0 = port 1, 1 = port 2
- M_AXIS_TREADY  input  1  downstream ready

## Operation
- States: IDLE, LOCK1, LOCK2. Reset -> IDLE.
- IDLE: no slave ready. Next state chosen from TVALID1/TVALID2 sampled this cycle:
  - only TVALID1 -> LOCK1; only TVALID2 -> LOCK2; neither -> IDLE.
  - both -> port not in last_grant register; last_grant resets to port 2, so port 1 wins the first contention after reset.
  - last_grant updated on every IDLE->LOCKx transition.
- LOCKx: S_AXIS_TREADYx = !out_valid || M_AXIS_TREADY; other port's TREADY = 0.
  - Beat accepted when TVALIDx && TREADYx; loads TDATA, TLAST, TID into output register, out_valid = 1.
  - Accepted beat with TLAST = 1 -> IDLE next cycle. Otherwise stay in LOCKx, regardless of gaps in TVALIDx.
- Output register: M_AXIS_* driven only from registers. out_valid clears when M_AXIS_TREADY = 1 and no new load the same cycle; simultaneous drain and load keeps out_valid = 1 with new contents.
- While M_AXIS_TVALID = 1 and M_AXIS_TREADY = 0: TDATA, TLAST, TID held stable.
- No beat is dropped, duplicated or reordered; packets from the two ports never interleave.

## Timing
- Reset values: M_AXIS_TVALID = 0, M_AXIS_TLAST = 0, M_AXIS_TID = 0, M_AXIS_TDATA = 0, both S_AXIS_TREADY = 0, state IDLE, last_grant = port 2.
- Asserted reset mid-packet: packet abandoned, output register cleared immediately (asynchronous); upstream must restart the packet.
- Arbitration costs one IDLE cycle per packet: first beat of a packet can be accepted no earlier than cycle N+1 after TVALID seen in IDLE at cycle N.
- Latency: beat accepted at edge N appears on M_AXIS_* after edge N; accepted at M no earlier than edge N+1.
- Throughput while locked with M_AXIS_TREADY = 1: one beat per cycle. Packet of L beats occupies L+1 cycles.
- Single-beat packet (TLAST on first beat): LOCKx for one cycle, IDLE next.
- Slave TREADY is combinational from M_AXIS_TREADY and out_valid only; never depends on slave TVALID.

## Test plan
- Single source: port 1 sends 4 beats 0x10..0x13, TLAST on 0x13, M_AXIS_TREADY = 1 -> M outputs same 4 beats in order, TID = 0, TLAST only on 0x13, first output one cycle after first acceptance.
- Contention: both ports valid from reset with 3-beat packets (port 1: 1,2,3; port 2: -1,-2,-3) repeated twice -> output order P1, P2, P1, P2, each packet contiguous, TID matching, one idle cycle between packets.
- Backpressure: port 2 packet of 5 beats, M_AXIS_TREADY toggles 1,0,0,1,... -> no loss/duplication, TDATA/TLAST/TID stable during every stall, S_AXIS_TREADY2 = 0 whenever out_valid = 1 and M_AXIS_TREADY = 0.
- Single-beat packets: port 1 continuously sends TLAST-every-beat values 7,8,9 while port 2 idle -> outputs 7,8,9 each separated by one idle cycle, TID = 0.
- Gapped packet: port 1 beat 0xA, TVALID1 low 3 cycles, beat 0xB with TLAST; port 2 valid throughout -> port 2 stalled (TREADY2 = 0) until 0xB delivered, then granted.
- Reset mid-packet: assert AXIS_ARESET after 2 of 4 beats with M_AXIS_TREADY = 0 -> M_AXIS_TVALID drops to 0 immediately, both TREADY = 0; after release, port 1 wins first contention.
